// File: rtl/tl_pkg.sv
// TileLink shared definitions: A-channel opcodes and beat-count helpers,
// used by the channel arbiters and routers.
package tl_pkg;

    localparam logic [2:0] TL_A_PUT_FULL      = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL   = 3'd1;
    localparam logic [2:0] TL_A_ARITHMETIC    = 3'd2;
    localparam logic [2:0] TL_A_LOGICAL       = 3'd3;
    localparam logic [2:0] TL_A_GET           = 3'd4;
    localparam logic [2:0] TL_A_HINT          = 3'd5;
    localparam logic [2:0] TL_A_ACQUIRE_BLOCK = 3'd6;
    localparam logic [2:0] TL_A_ACQUIRE_PERM  = 3'd7;

    localparam int TL_BEAT_CNT_W = 8;

    function automatic logic tl_a_has_data(input logic [2:0] opcode);
        logic has_data;
        case (opcode)
            TL_A_PUT_FULL, TL_A_PUT_PARTIAL,
            TL_A_ARITHMETIC, TL_A_LOGICAL: has_data = 1'b1;
            default:                       has_data = 1'b0;
        endcase
        return has_data;
    endfunction

    // Number of beats in a message; a 2 KiB burst at 64-bit data returns 256.
    function automatic logic [15:0] tl_beats(input logic [2:0] opcode,
                                             input logic [3:0] size,
                                             input int         data_w);
        int lg;
        lg = $clog2(data_w / 8);
        if (tl_a_has_data(opcode) && (int'(size) > lg))
            return 16'(1) << (int'(size) - lg);
        return 16'd1;
    endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Combinational N-way round-robin pick: first valid at or after ptr wins.
module tl_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!any && valid[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/tl_a_arbiter.sv
// TileLink A-channel round-robin arbiter with burst lock and source widening.
// Define TL_A_ARB_OUTREG_EN for a one-entry output register; otherwise pass-through.
module tl_a_arbiter #(
    parameter int N_CLIENTS = 4,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int SOURCE_W  = 4,
    parameter int CID_W     = $clog2(N_CLIENTS)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [N_CLIENTS-1:0]              cli_a_valid_i,
    output logic [N_CLIENTS-1:0]              cli_a_ready_o,
    input  logic [N_CLIENTS*3-1:0]            cli_a_opcode_i,
    input  logic [N_CLIENTS*3-1:0]            cli_a_param_i,
    input  logic [N_CLIENTS*4-1:0]            cli_a_size_i,
    input  logic [N_CLIENTS*SOURCE_W-1:0]     cli_a_source_i,
    input  logic [N_CLIENTS*ADDR_W-1:0]       cli_a_address_i,
    input  logic [N_CLIENTS*DATA_W-1:0]       cli_a_data_i,
    input  logic [N_CLIENTS*(DATA_W/8)-1:0]   cli_a_mask_i,
    input  logic [N_CLIENTS-1:0]              cli_a_corrupt_i,
    output logic                              mgr_a_valid_o,
    input  logic                              mgr_a_ready_i,
    output logic [2:0]                        mgr_a_opcode_o,
    output logic [2:0]                        mgr_a_param_o,
    output logic [3:0]                        mgr_a_size_o,
    output logic [SOURCE_W+CID_W-1:0]         mgr_a_source_o,
    output logic [ADDR_W-1:0]                 mgr_a_address_o,
    output logic [DATA_W/8-1:0]               mgr_a_mask_o,
    output logic [DATA_W-1:0]                 mgr_a_data_o,
    output logic                              mgr_a_corrupt_o
);
    import tl_pkg::*;

    localparam int MASK_W = DATA_W / 8;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [2:0]          opcode_arr  [N_CLIENTS];
    logic [2:0]          param_arr   [N_CLIENTS];
    logic [3:0]          size_arr    [N_CLIENTS];
    logic [SOURCE_W-1:0] source_arr  [N_CLIENTS];
    logic [ADDR_W-1:0]   address_arr [N_CLIENTS];
    logic [DATA_W-1:0]   data_arr    [N_CLIENTS];
    logic [MASK_W-1:0]   mask_arr    [N_CLIENTS];
    logic [N_CLIENTS-1:0] lock_mask;

    logic [0:0]               state_reg;
    logic [CID_W-1:0]         lock_reg;
    logic [TL_BEAT_CNT_W-1:0] cnt_reg;
    logic [CID_W-1:0]         ptr_reg;

    generate
        for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_unpack
            assign opcode_arr[gi]  = cli_a_opcode_i[gi*3 +: 3];
            assign param_arr[gi]   = cli_a_param_i[gi*3 +: 3];
            assign size_arr[gi]    = cli_a_size_i[gi*4 +: 4];
            assign source_arr[gi]  = cli_a_source_i[gi*SOURCE_W +: SOURCE_W];
            assign address_arr[gi] = cli_a_address_i[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi]    = cli_a_data_i[gi*DATA_W +: DATA_W];
            assign mask_arr[gi]    = cli_a_mask_i[gi*MASK_W +: MASK_W];
            assign lock_mask[gi]   = (lock_reg == CID_W'(gi));
        end
    endgenerate

    // During a burst only the locked client may compete.
    logic [N_CLIENTS-1:0] eff_valid;
    assign eff_valid = (state_reg == ST_BURST) ? (cli_a_valid_i & lock_mask) : cli_a_valid_i;

    logic [N_CLIENTS-1:0] grant;
    logic [CID_W-1:0]     g_idx;
    logic                 g_any;

    tl_rr_pick #(.N(N_CLIENTS), .IDX_W(CID_W)) u_pick (
        .valid (eff_valid),
        .ptr   (ptr_reg),
        .grant (grant),
        .idx   (g_idx),
        .any   (g_any)
    );

    logic [2:0]                sel_opcode, sel_param;
    logic [3:0]                sel_size;
    logic [SOURCE_W+CID_W-1:0] sel_source;
    logic [ADDR_W-1:0]         sel_address;
    logic [DATA_W-1:0]         sel_data;
    logic [MASK_W-1:0]         sel_mask;
    logic                      sel_corrupt;

    assign sel_opcode  = opcode_arr[g_idx];
    assign sel_param   = param_arr[g_idx];
    assign sel_size    = size_arr[g_idx];
    assign sel_source  = {g_idx, source_arr[g_idx]};
    assign sel_address = address_arr[g_idx];
    assign sel_data    = data_arr[g_idx];
    assign sel_mask    = mask_arr[g_idx];
    assign sel_corrupt = cli_a_corrupt_i[g_idx];

    logic slot_free;
`ifdef TL_A_ARB_OUTREG_EN
    logic out_valid_reg;
    assign slot_free = !out_valid_reg || mgr_a_ready_i;
`else
    assign slot_free = mgr_a_ready_i;
`endif

    logic accept;
    assign accept        = g_any && slot_free && !rst_i;
    assign cli_a_ready_o = accept ? grant : '0;

    // beats[7:0]-1 wraps 256 to 255, so the 8-bit counter covers 2 KiB bursts.
    logic [15:0]              beats;
    logic [TL_BEAT_CNT_W-1:0] cnt_load;
    logic                     last_beat;
    logic [CID_W-1:0]         next_ptr;

    assign beats     = tl_beats(sel_opcode, sel_size, DATA_W);
    assign cnt_load  = beats[TL_BEAT_CNT_W-1:0] - TL_BEAT_CNT_W'(1);
    assign last_beat = (state_reg == ST_IDLE) ? (beats == 16'd1) : (cnt_reg == TL_BEAT_CNT_W'(1));
    assign next_ptr  = (g_idx == CID_W'(N_CLIENTS - 1)) ? '0 : g_idx + CID_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            lock_reg  <= '0;
            cnt_reg   <= '0;
            ptr_reg   <= '0;
        end else if (accept) begin
            if (state_reg == ST_IDLE && beats != 16'd1) begin
                state_reg <= ST_BURST;
                lock_reg  <= g_idx;
                cnt_reg   <= cnt_load;
            end else if (state_reg == ST_BURST) begin
                cnt_reg <= cnt_reg - TL_BEAT_CNT_W'(1);
                if (cnt_reg == TL_BEAT_CNT_W'(1))
                    state_reg <= ST_IDLE;
            end
            if (last_beat)
                ptr_reg <= next_ptr;
        end
    end

`ifdef TL_A_ARB_OUTREG_EN
    logic [2:0]                out_opcode_reg, out_param_reg;
    logic [3:0]                out_size_reg;
    logic [SOURCE_W+CID_W-1:0] out_source_reg;
    logic [ADDR_W-1:0]         out_address_reg;
    logic [DATA_W-1:0]         out_data_reg;
    logic [MASK_W-1:0]         out_mask_reg;
    logic                      out_corrupt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_reg   <= 1'b0;
            out_opcode_reg  <= '0;
            out_param_reg   <= '0;
            out_size_reg    <= '0;
            out_source_reg  <= '0;
            out_address_reg <= '0;
            out_data_reg    <= '0;
            out_mask_reg    <= '0;
            out_corrupt_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg   <= 1'b1;
            out_opcode_reg  <= sel_opcode;
            out_param_reg   <= sel_param;
            out_size_reg    <= sel_size;
            out_source_reg  <= sel_source;
            out_address_reg <= sel_address;
            out_data_reg    <= sel_data;
            out_mask_reg    <= sel_mask;
            out_corrupt_reg <= sel_corrupt;
        end else if (mgr_a_ready_i) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign mgr_a_valid_o   = out_valid_reg;
    assign mgr_a_opcode_o  = out_opcode_reg;
    assign mgr_a_param_o   = out_param_reg;
    assign mgr_a_size_o    = out_size_reg;
    assign mgr_a_source_o  = out_source_reg;
    assign mgr_a_address_o = out_address_reg;
    assign mgr_a_data_o    = out_data_reg;
    assign mgr_a_mask_o    = out_mask_reg;
    assign mgr_a_corrupt_o = out_corrupt_reg;
`else
    assign mgr_a_valid_o   = g_any && !rst_i;
    assign mgr_a_opcode_o  = sel_opcode;
    assign mgr_a_param_o   = sel_param;
    assign mgr_a_size_o    = sel_size;
    assign mgr_a_source_o  = sel_source;
    assign mgr_a_address_o = sel_address;
    assign mgr_a_data_o    = sel_data;
    assign mgr_a_mask_o    = sel_mask;
    assign mgr_a_corrupt_o = sel_corrupt;
`endif

endmodule
